// File: rtl/cl_read_reorder_pkg.sv
// Shared types for the cache-line read reorder stage.
// The default ring depth sets the slot/pointer typedefs.
package cl_read_reorder_pkg;

    localparam int DEPTH_LOG2_DEF = 5;
    localparam int DEPTH          = 1 << DEPTH_LOG2_DEF;

    typedef logic [DEPTH_LOG2_DEF-1:0] t_slot_idx;
    typedef logic [DEPTH_LOG2_DEF:0]   t_ptr;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } t_state;

endpackage

// File: rtl/reorder_slot_ram.sv
// Simple dual-port slot storage.
// The registered read output holds its value whenever rd_en is low.
module reorder_slot_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // No reset so the array and output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cl_read_reorder.sv
// Issues sequential cache-line reads tagged by ring slot, accepts responses
// in any order and releases lines downstream strictly in address order.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for run; responses are dropped silently
// ST_ISSUE  | issuing reads while the ring has room and lines remain
// ST_DRAIN  | all reads issued; waiting for the last ordered handshake
// ST_FINISH | pulse done once, then back to idle
module cl_read_reorder
    import cl_read_reorder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int MDATA_W    = 16,
    parameter int CLADDR_W   = 42
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [63:0]         num_lines,
    input  logic [CLADDR_W-1:0] first_clAddr,
    input  logic                c0TxAlmFull,
    output logic                c0TxValid,
    output logic [CLADDR_W-1:0] c0TxAddr,
    output logic [MDATA_W-1:0]  c0TxMdata,
    input  logic                c0RxValid,
    input  logic [MDATA_W-1:0]  c0RxMdata,
    input  logic [511:0]        c0RxData,
    output logic                out_valid,
    output logic [511:0]        out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                tag_err
);

    localparam int NSLOT = 1 << DEPTH_LOG2;

    t_state                state_q, state_d;
    logic [63:0]           num_lines_q, num_lines_d;
    logic [63:0]           issued_q, issued_d;
    logic [63:0]           retired_q, retired_d;
    logic [CLADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [DEPTH_LOG2:0]   iss_ptr_q, iss_ptr_d;
    logic [DEPTH_LOG2:0]   ret_ptr_q, ret_ptr_d;
    logic [NSLOT-1:0]      pending_q, pending_d;
    logic [NSLOT-1:0]      filled_q, filled_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [CLADDR_W-1:0]   tx_addr_q, tx_addr_d;
    logic [MDATA_W-1:0]    tx_mdata_q, tx_mdata_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic                  tag_err_q, tag_err_d;

    logic                  active;
    logic [DEPTH_LOG2:0]   occupancy;
    logic [DEPTH_LOG2-1:0] iss_slot, ret_slot, rx_slot;
    logic                  rx_tag_ok, rx_accept, retire, can_issue;

    always_comb begin
        state_d     = state_q;
        num_lines_d = num_lines_q;
        issued_d    = issued_q;
        retired_d   = retired_q;
        base_addr_d = base_addr_q;
        iss_ptr_d   = iss_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        pending_d   = pending_q;
        filled_d    = filled_q;
        tx_valid_d  = 1'b0;
        tx_addr_d   = tx_addr_q;
        tx_mdata_d  = tx_mdata_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        tag_err_d   = tag_err_q;

        active    = (state_q != ST_IDLE);
        occupancy = iss_ptr_q - ret_ptr_q;
        iss_slot  = iss_ptr_q[DEPTH_LOG2-1:0];
        ret_slot  = ret_ptr_q[DEPTH_LOG2-1:0];
        rx_slot   = c0RxMdata[DEPTH_LOG2-1:0];
        rx_tag_ok = ((c0RxMdata >> DEPTH_LOG2) == '0);

        // A full ring shows up as the extra pointer bit being set.
        can_issue = (state_q == ST_ISSUE) && !c0TxAlmFull &&
                    (issued_q < num_lines_q) && !occupancy[DEPTH_LOG2];
        rx_accept = active && c0RxValid && rx_tag_ok &&
                    pending_q[rx_slot] && !filled_q[rx_slot];
        retire    = active && filled_q[ret_slot] && (!out_valid_q || out_ready);

        if (active && c0RxValid && !rx_accept) begin
            tag_err_d = 1'b1;
        end

        if (retire) begin
            pending_d[ret_slot] = 1'b0;
            filled_d[ret_slot]  = 1'b0;
            ret_ptr_d           = ret_ptr_q + (DEPTH_LOG2+1)'(1);
            retired_d           = retired_q + 64'd1;
            out_valid_d         = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Issue never targets ret_slot while it is occupied, so the set
        // below cannot collide with the retire clear above.
        if (can_issue) begin
            tx_valid_d          = 1'b1;
            tx_addr_d           = base_addr_q + issued_q[CLADDR_W-1:0];
            tx_mdata_d          = MDATA_W'(iss_slot);
            pending_d[iss_slot] = 1'b1;
            iss_ptr_d           = iss_ptr_q + (DEPTH_LOG2+1)'(1);
            issued_d            = issued_q + 64'd1;
        end

        if (rx_accept) begin
            filled_d[rx_slot] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    num_lines_d = num_lines;
                    base_addr_d = first_clAddr;
                    issued_d    = '0;
                    retired_d   = '0;
                    iss_ptr_d   = '0;
                    ret_ptr_d   = '0;
                    state_d     = (num_lines == 64'd0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (can_issue && (issued_d == num_lines_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((retired_q == num_lines_q) && out_valid_q && out_ready) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end
            end
            ST_FINISH: begin
                // Entered without a pending pulse on the zero-length path.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_lines_q <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            base_addr_q <= '0;
            iss_ptr_q   <= '0;
            ret_ptr_q   <= '0;
            pending_q   <= '0;
            filled_q    <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_lines_q <= num_lines_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            base_addr_q <= base_addr_d;
            iss_ptr_q   <= iss_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            pending_q   <= pending_d;
            filled_q    <= filled_d;
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            tag_err_q   <= tag_err_d;
        end
    end

    reorder_slot_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (512)
    ) u_slot_ram (
        .clk     (clk),
        .wr_en   (rx_accept),
        .wr_addr (rx_slot),
        .wr_data (c0RxData),
        .rd_en   (retire),
        .rd_addr (ret_slot),
        .rd_data (out_data)
    );

    assign c0TxValid = tx_valid_q;
    assign c0TxAddr  = tx_addr_q;
    assign c0TxMdata = tx_mdata_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign tag_err   = tag_err_q;

endmodule

// File: tb/tb_cl_read_reorder.sv
// Scoreboard bench for cl_read_reorder: expected requests and ordered lines
// are queued at run time and a negedge monitor pops and compares them.
module tb_cl_read_reorder;

    logic         clk = 1'b0;
    logic         reset, run;
    logic [63:0]  num_lines;
    logic [41:0]  first_clAddr;
    logic         c0TxAlmFull, c0TxValid;
    logic [41:0]  c0TxAddr;
    logic [15:0]  c0TxMdata;
    logic         c0RxValid;
    logic [15:0]  c0RxMdata;
    logic [511:0] c0RxData;
    logic         out_valid, out_ready, busy, done, tag_err;
    logic [511:0] out_data;

    cl_read_reorder dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .num_lines    (num_lines),
        .first_clAddr (first_clAddr),
        .c0TxAlmFull  (c0TxAlmFull),
        .c0TxValid    (c0TxValid),
        .c0TxAddr     (c0TxAddr),
        .c0TxMdata    (c0TxMdata),
        .c0RxValid    (c0RxValid),
        .c0RxMdata    (c0RxMdata),
        .c0RxData     (c0RxData),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .tag_err      (tag_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [41:0]  exp_addr_q[$];
    logic [15:0]  exp_tag_q[$];
    logic [511:0] exp_data_q[$];

    int checks = 0, errors = 0;
    int reqs_seen = 0, done_seen = 0, done_cyc = -1;
    int first_req_cyc = -1, first_ov_cyc = -1, run_cyc = 0;
    logic         prev_alm = 1'b0, prev_stall = 1'b0;
    logic [511:0] prev_data = '0;

    function automatic logic [511:0] line_data(input logic [41:0] a);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            kk = k[3:0];
            d[k*32 +: 32] = {a[27:0], kk} ^ 32'hC0DE_0000;
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: requests, ordered output, stall stability, done pulses.
    always @(negedge clk) begin
        if (reset) begin
            prev_alm   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (c0TxValid) begin
                if (exp_addr_q.size() == 0) begin
                    flag("unexpected_req");
                end else begin
                    chk("req_addr", c0TxAddr, exp_addr_q.pop_front());
                    chk("req_tag", c0TxMdata, exp_tag_q.pop_front());
                end
                chk("req_after_almfull", prev_alm, 1'b0);
                if (reqs_seen == 0) first_req_cyc = cyc;
                reqs_seen++;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) flag("unexpected_out");
                else chk("out_data", out_data, exp_data_q.pop_front());
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
            prev_alm   = c0TxAlmFull;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic start_run(input int n, input logic [41:0] base);
        reqs_seen     = 0;
        first_req_cyc = -1;
        first_ov_cyc  = -1;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(base + 42'(i));
            exp_tag_q.push_back(16'(i % 32));
            exp_data_q.push_back(line_data(base + 42'(i)));
        end
        @(posedge clk); #1;
        num_lines    = 64'(n);
        first_clAddr = base;
        run          = 1'b1;
        run_cyc      = cyc;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    // In-order responder that only answers lines already requested.
    task automatic drive(input int n, input logic [41:0] base, input bit toggle,
                         input bit use_alm, input int budget);
        int ri = 0;
        int d0 = done_seen;
        int k  = 0;
        while (done_seen == d0 && k < budget) begin
            @(posedge clk); #1;
            out_ready   = toggle ? ~out_ready : 1'b1;
            c0TxAlmFull = use_alm && (cyc - run_cyc) >= 3 && (cyc - run_cyc) <= 6;
            if (ri < n && ri < reqs_seen) begin
                c0RxValid = 1'b1;
                c0RxMdata = 16'(ri % 32);
                c0RxData  = line_data(base + 42'(ri));
                ri++;
            end else begin
                c0RxValid = 1'b0;
            end
            k++;
        end
        if (done_seen == d0) flag("drive_timeout");
        c0RxValid   = 1'b0;
        out_ready   = 1'b1;
        c0TxAlmFull = 1'b0;
    endtask

    task automatic resp_cycle(input int line, input logic [41:0] base, input logic [15:0] tag);
        @(posedge clk); #1;
        c0RxValid = 1'b1;
        c0RxMdata = tag;
        c0RxData  = line_data(base + 42'(line));
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int k = 0;
        while (reqs_seen < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (reqs_seen < n) flag("wait_reqs_timeout");
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (done_seen == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_seen == d0) flag("wait_done_timeout");
    endtask

    task automatic end_check(input string name, input int d0, input logic err_exp);
        chk({name, "_done_count"}, done_seen - d0, 1);
        chk({name, "_req_left"}, exp_addr_q.size(), 0);
        chk({name, "_out_left"}, exp_data_q.size(), 0);
        chk({name, "_tag_err"}, tag_err, err_exp);
        chk({name, "_busy"}, busy, 1'b0);
    endtask

    task automatic reset_values(input string name);
        chk({name, "_txvalid"}, c0TxValid, 1'b0);
        chk({name, "_txaddr"}, c0TxAddr, 42'd0);
        chk({name, "_txmdata"}, c0TxMdata, 16'd0);
        chk({name, "_out_valid"}, out_valid, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_tag_err"}, tag_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int t0_cyc;
        reset = 1'b1; run = 1'b0; num_lines = '0; first_clAddr = '0;
        c0TxAlmFull = 1'b0; c0RxValid = 1'b0; c0RxMdata = '0; c0RxData = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        reset_values("reset");

        // 8 lines, in-order responses.
        d0 = done_seen;
        start_run(8, 42'h100);
        drive(8, 42'h100, 1'b0, 1'b0, 200);
        end_check("t1", d0, 1'b0);
        chk("t1_first_req_latency", first_req_cyc - run_cyc, 2);
        chk("t1_req_count", reqs_seen, 8);

        // 4 lines, responses 3,1,0,2.
        d0 = done_seen;
        start_run(4, 42'h200);
        wait_reqs(4, 100);
        resp_cycle(3, 42'h200, 16'd3);
        resp_cycle(1, 42'h200, 16'd1);
        resp_cycle(0, 42'h200, 16'd0);
        t0_cyc = cyc;
        resp_cycle(2, 42'h200, 16'd2);
        @(posedge clk); #1 c0RxValid = 1'b0;
        wait_done(d0, 100);
        #1;
        end_check("t2", d0, 1'b0);
        chk("t2_first_out_latency", first_ov_cyc - t0_cyc, 2);

        // 40 lines, ring fills at 32 while responses are withheld.
        d0 = done_seen;
        start_run(40, 42'h1000);
        repeat (60) @(posedge clk);
        #1;
        chk("t3_stall_req_count", reqs_seen, 32);
        chk("t3_stall_out_valid", out_valid, 1'b0);
        drive(40, 42'h1000, 1'b0, 1'b0, 400);
        end_check("t3", d0, 1'b0);
        chk("t3_req_count", reqs_seen, 40);

        // 16 lines, out_ready toggling, AlmFull in cycles 3-6.
        d0 = done_seen;
        start_run(16, 42'h2000);
        drive(16, 42'h2000, 1'b1, 1'b1, 300);
        end_check("t4", d0, 1'b0);
        chk("t4_req_count", reqs_seen, 16);

        // Zero lines.
        d0 = done_seen;
        start_run(0, 42'h3000);
        wait_done(d0, 20);
        chk("t5_done_latency", done_cyc - run_cyc, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_req_count", reqs_seen, 0);
        chk("t5_done_count", done_seen - d0, 1);

        // Unissued tag and tag with high bits set.
        d0 = done_seen;
        start_run(2, 42'h4000);
        wait_reqs(2, 50);
        resp_cycle(5, 42'h4000, 16'd5);
        resp_cycle(1, 42'h4000, 16'h0021);
        @(posedge clk); #1 c0RxValid = 1'b0;
        @(posedge clk); #1;
        chk("t6_tag_err_set", tag_err, 1'b1);
        chk("t6_no_early_out", out_valid, 1'b0);
        drive(2, 42'h4000, 1'b0, 1'b0, 100);
        end_check("t6", d0, 1'b1);

        // Reset mid-run, then late responses while idle.
        d0 = done_seen;
        start_run(20, 42'h5000);
        wait_reqs(10, 100);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_addr_q.delete();
        exp_tag_q.delete();
        exp_data_q.delete();
        reset_values("t7_reset");
        for (int i = 0; i < 10; i++) resp_cycle(i, 42'h5000, 16'(i));
        @(posedge clk); #1 c0RxValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t7_late_tag_err", tag_err, 1'b0);
        chk("t7_late_out_valid", out_valid, 1'b0);
        chk("t7_late_busy", busy, 1'b0);
        chk("t7_no_done", done_seen - d0, 0);
        d0 = done_seen;
        start_run(2, 42'h6000);
        drive(2, 42'h6000, 1'b0, 1'b0, 100);
        end_check("t7", d0, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cl_read_reorder.md
# cl_read_reorder

Read-issue and in-order collection stage between the MPF read channel (c0) and the 512-to-64 read buffer. It generates sequential cache-line read requests tagged with a slot index and accepts responses in any order. Each response lands in a slot of an on-chip ring, and lines are released to the downstream buffer strictly in address order through a valid/ready port. Line-level done/busy status is reported to the AFU state machine.

## Interface
- DEPTH_LOG2, default 5: log2 of reorder slots (32); bounds reads in flight.
- MDATA_W, default 16: width of request/response tag field.
- CLADDR_W, default 42: cache-line address width (matches t_cci_clAddr).

- clk  in  1  clock.
- reset  in  1  synchronous, active-high; one clock; resets all state.
- run  in  1  single-cycle start pulse; sampled only in IDLE.
- num_lines  in  64  lines to read; latched on run.
- first_clAddr  in  CLADDR_W  line address of first read; latched on run.
- c0TxAlmFull  in  1  MPF back-pressure.
- c0TxValid  out  1  read request valid (registered).
- c0TxAddr  out  CLADDR_W  request line address (registered).
- c0TxMdata  out  MDATA_W  tag = slot index, zero-extended.
- c0RxValid  in  1  read response valid (top level qualifies with response type).
- c0RxMdata  in  MDATA_W  response tag.
- c0RxData  in  512  response line.
- out_valid  out  1  ordered line available.
- out_data  out  512  ordered line.
- out_ready  in  1  downstream accepts (top: !read_buffer_full_n).
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse, all lines delivered.
- tag_err  out  1  sticky: response to a non-pending slot.

## Operation
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on run, latch num_lines and first_clAddr; clear counters. Go to FINISH if num_lines==0, else ISSUE. run outside IDLE is ignored.
- ISSUE: issue condition is !c0TxAlmFull && issued<num_lines && occupancy<2^DEPTH_LOG2, where occupancy=iss_ptr-ret_ptr on DEPTH_LOG2+1 bits, evaluated before this cycle's retire.
  - On issue: addr=first_clAddr+issued (modulo 2^CLADDR_W), tag=iss_ptr[DEPTH_LOG2-1:0].
  - On issue: set pending[slot], increment iss_ptr and issued.
  - When issued==num_lines, go to DRAIN.
- Response handling, any non-IDLE state: if pending[tag] && !filled[tag], write data to slot RAM and set filled[tag].
  - Otherwise discard the response and set tag_err.
  - Tag bits above DEPTH_LOG2 must be zero; if not, treat as error.
- Retire: advance when filled[ret_ptr] && (!out_valid || out_ready).
  - On advance: RAM read at ret_ptr, clear pending/filled, increment ret_ptr and retired.
  - Output is held while out_valid && !out_ready.
- DRAIN: stop issuing; go to FINISH when retired==num_lines and the final out_valid handshake completes.
- FINISH: pulse done for one cycle, then return to IDLE.
- A response in the same cycle as retire on a different slot: both proceed. A response to slot ret_ptr in the same cycle is visible next cycle.
- A response arriving in IDLE (e.g. after reset mid-operation) is discarded silently. tag_err is not set.
- Reset values: c0TxValid=0, c0TxAddr=0, c0TxMdata=0, out_valid=0, busy=0, done=0, tag_err=0. out_data is undefined while out_valid=0. All pending/filled bits clear.

## Timing
- Request: issue condition evaluated in cycle N; c0TxValid/addr/tag are registered and valid in N+1.
- c0TxAlmFull is honoured with zero extra slack; MPF tolerates more.
- Response to output: response in cycle T is written at the end of T; filled is visible in T+1; earliest out_valid is T+2.
- out_data is the registered RAM output (read latency 1).
- Throughput: one request per cycle and one output per cycle sustained with out_ready=1 and responses keeping up.
- done asserts the cycle after the final output handshake.

## Structure
- Package cl_read_reorder_pkg: t_slot_idx (DEPTH_LOG2 bits), t_ptr (DEPTH_LOG2+1 bits), t_state enum, DEPTH localparam.
- Sub-module reorder_slot_ram: simple dual-port, one write port, one read port with rd_en and registered output that holds when rd_en=0. 2^DEPTH_LOG2 × 512, inferred as M20K.

## Test plan
- num_lines=8, first_clAddr=0x100, in-order responses, out_ready=1 -> addresses 0x100..0x107, tags 0..7; 8 outputs in order; one done pulse; tag_err=0.
- num_lines=4, responses returned with tags 3,1,0,2 -> outputs are tag 0,1,2,3 data; first out_valid 2 cycles after tag-0 response.
- num_lines=40, responses withheld -> exactly 32 requests, then stall; after releasing responses the remaining 8 issue; 40 ordered outputs.
- num_lines=16, out_ready toggling 1/0 every cycle, c0TxAlmFull high for cycles 3-6 -> no request while AlmFull is seen; out_data stable while !out_ready; no loss or duplication.
- num_lines=0 -> no requests; done 2 cycles after run. Response with an unissued tag during a run -> tag_err=1, output stream unaffected.
- reset asserted mid-run with 10 reads pending, then late responses arrive -> all outputs at reset values; responses discarded; tag_err stays 0; a new run of 2 lines completes.
